// File: rtl/register_file_multiport.sv
// Multi-port register file with registered reads, highest-port-wins writes and a one-entry-per-cycle clear engine.
// Optional same-edge write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_WRITE-1:0]             write_enable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  write_selector,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  write_value,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_selector,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read_value,
  input  logic                             clear_request,
  output logic                             clear_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                         state, state_next;
  logic [ADDR_WIDTH-1:0]          counter, counter_next;
  logic [DATA_WIDTH-1:0]          entry [DEPTH];
  logic [NUM_WRITE-1:0]           commit;
  logic [NUM_READ*DATA_WIDTH-1:0] read_next;

  function automatic logic writable(input logic [ADDR_WIDTH-1:0] sel);
    return !((ZERO_REG != 0) && (sel == '0));
  endfunction

  // A write only commits while idle and never to a hardwired-zero entry 0.
  always_comb begin
    commit = '0;
    for (int w = 0; w < NUM_WRITE; w++)
      commit[w] = write_enable[w] && (state == IDLE) &&
                  writable(write_selector[w*ADDR_WIDTH +: ADDR_WIDTH]);
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      IDLE: begin
        if (clear_request) begin
          state_next   = CLEAR;
          counter_next = '0;
        end
      end
      CLEAR: begin
        counter_next = counter + ADDR_WIDTH'(1);
        if (counter == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  assign clear_busy = (state == CLEAR);

  // Later ports overwrite earlier ones in the loop, so the highest index wins on a collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (state == CLEAR) begin
      entry[counter] <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++)
        if (commit[w])
          entry[write_selector[w*ADDR_WIDTH +: ADDR_WIDTH]] <= write_value[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    read_next = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      read_next[r*DATA_WIDTH +: DATA_WIDTH] = entry[read_selector[r*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WRITE; w++)
        if (commit[w] && (write_selector[w*ADDR_WIDTH +: ADDR_WIDTH] ==
                          read_selector[r*ADDR_WIDTH +: ADDR_WIDTH]))
          read_next[r*DATA_WIDTH +: DATA_WIDTH] = write_value[w*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
  end

  // Read stage: one-cycle registered output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) read_value <= '0;
    else       read_value <= read_next;
  end

endmodule

// File: tb/tb_register_file_multiport.sv
// Directed bench for register_file_multiport (two write ports, two read ports, 32 entries, entry 0 hardwired).
module tb_register_file_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic [NW-1:0]      write_enable;
  logic [NW*AW-1:0]   write_selector;
  logic [NW*DW-1:0]   write_value;
  logic [NR*AW-1:0]   read_selector;
  logic [NR*DW-1:0]   read_value;
  logic               clear_request;
  logic               clear_busy;

  int total = 0;
  int bad   = 0;

  register_file_multiport #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(1)
  ) dut (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_selector(write_selector), .write_value(write_value),
    .read_selector(read_selector), .read_value(read_value),
    .clear_request(clear_request), .clear_busy(clear_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [AW-1:0] sel, input logic [DW-1:0] val);
    write_enable[p]            = en;
    write_selector[p*AW +: AW] = sel;
    write_value[p*DW +: DW]    = val;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] sel);
    read_selector[p*AW +: AW] = sel;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return read_value[p*DW +: DW];
  endfunction

  initial begin
    int cnt;
    reset = 1'b1;
    write_enable = '0; write_selector = '0; write_value = '0;
    read_selector = '0; clear_request = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset with live data, then every selector reads 0
    set_wr(0, 1'b1, 5'd3, 32'h0000_0055);
    cyc();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_rd(0, 5'd3);
    cyc();
    check("pre_reset_rd", rd(0), 32'h0000_0055);
    reset = 1'b1;
    #1;
    check("async_reset_rd", rd(0), 32'h0);
    check("async_reset_busy", {31'b0, clear_busy}, 32'h0);
    cyc();
    reset = 1'b0;
    for (int s = 0; s < 32; s++) begin
      set_rd(0, AW'(s));
      set_rd(1, AW'(31 - s));
      cyc();
      check("reset_rd0", rd(0), 32'h0);
      check("reset_rd1", rd(1), 32'h0);
    end

    // Basic write then read on both ports
    set_wr(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    cyc();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_rd(0, 5'd3); set_rd(1, 5'd3);
    cyc();
    check("wr3_rd0", rd(0), 32'hDEAD_BEEF);
    check("wr3_rd1", rd(1), 32'hDEAD_BEEF);

    // Entry 0 ignores writes and never forwards
    set_wr(0, 1'b1, 5'd0, 32'h0000_1234);
    set_rd(0, 5'd0);
    cyc();
    check("zero_same_edge", rd(0), 32'h0);
    set_wr(0, 1'b0, 5'd0, 32'h0);
    cyc();
    check("zero_next", rd(0), 32'h0);

    // Two ports hit entry 7 at once: port 1 wins
    set_wr(0, 1'b1, 5'd7, 32'h11);
    set_wr(1, 1'b1, 5'd7, 32'h22);
    set_rd(1, 5'd7);
    cyc();
    check("collide_same_edge", rd(1), BYPASS ? 32'h22 : 32'h0);
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_wr(1, 1'b0, 5'd0, 32'h0);
    set_rd(0, 5'd7);
    cyc();
    check("collide_rd0", rd(0), 32'h22);
    check("collide_rd1", rd(1), 32'h22);

    // Overwrite 1 with A5A5A5A5 while reading the same entry
    set_wr(0, 1'b1, 5'd5, 32'h1);
    cyc();
    set_wr(0, 1'b1, 5'd5, 32'hA5A5_A5A5);
    set_rd(0, 5'd5); set_rd(1, 5'd3);
    cyc();
    check("bypass_rd0", rd(0), BYPASS ? 32'hA5A5_A5A5 : 32'h1);
    check("bypass_other", rd(1), 32'hDEAD_BEEF);
    set_wr(0, 1'b0, 5'd0, 32'h0);
    cyc();
    check("after_bypass", rd(0), 32'hA5A5_A5A5);

    // Fill with FF, then sequential clear with writes and requests attempted while busy
    for (int s = 0; s < 32; s++) begin
      set_wr(0, 1'b1, AW'(s), 32'hFF);
      cyc();
    end
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_rd(0, 5'd4); set_rd(1, 5'd0);
    cyc();
    check("fill_rd4", rd(0), 32'hFF);
    check("fill_rd0", rd(1), 32'h0);
    check("idle_busy", {31'b0, clear_busy}, 32'h0);
    clear_request = 1'b1;
    set_rd(0, 5'd31); set_rd(1, 5'd2);
    cyc();
    cnt = 0;
    set_wr(0, 1'b1, 5'd31, 32'h0BAD);
    set_wr(1, 1'b1, 5'd9, 32'h0BAD);
    while (clear_busy && cnt < 40) begin
      cnt++;
      cyc();
      if (cnt == 10) begin
        check("clear_live_old", rd(0), 32'hFF);
        check("clear_live_wiped", rd(1), 32'h0);
      end
    end
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_wr(1, 1'b0, 5'd0, 32'h0);
    clear_request = 1'b0;
    check("busy_cycles", 32'(cnt), 32'd32);
    cyc();
    check("busy_no_restart", {31'b0, clear_busy}, 32'h0);
    for (int s = 0; s < 32; s += 2) begin
      set_rd(0, AW'(s));
      set_rd(1, AW'(s + 1));
      cyc();
      check("cleared_rd0", rd(0), 32'h0);
      check("cleared_rd1", rd(1), 32'h0);
    end

    // Reset in the middle of a clear aborts it
    set_wr(0, 1'b1, 5'd20, 32'h77);
    cyc();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    clear_request = 1'b1;
    cyc();
    clear_request = 1'b0;
    cyc(); cyc();
    check("mid_clear_busy", {31'b0, clear_busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, clear_busy}, 32'h0);
    cyc();
    reset = 1'b0;
    set_rd(0, 5'd20);
    cyc();
    check("abort_rd20", rd(0), 32'h0);
    check("abort_idle", {31'b0, clear_busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
